// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
//   Turns the byte stream from the UART receiver into SDRAM commands. It
//   parses framed commands:
//     SOF, OP, A[23:16], A[15:8], A[7:0], LEN, payload (write only), CHK
//   CHK is the XOR of every byte from OP through the last payload byte.
//   A write payload is held in a local buffer until its checksum is verified.
//   After that, one command is issued, followed by the payload stream.
//
// Handshakes:
//   A transfer happens on a rising sclk edge where valid && ready.
//   A valid signal, and everything it qualifies, stays stable until that
//   transfer. Valid never waits for ready.
//
// Ports:
//   sclk, reset          clock and asynchronous active-low reset
//   rx_data, rx_vld      received byte and its 1-cycle strobe
//   cmd_valid/cmd_ready  command handshake (cmd_wr, cmd_addr, cmd_len)
//   wd_valid/wd_ready    write payload handshake (wd_data)
//   busy                 frame in progress or command/payload outstanding
//   frame_err, err_code  1-cycle error pulse; the code is held until the
//                        next error (0 op, 1 len, 2 chk, 3 timeout)
//   ovr                  1-cycle pulse for a byte dropped during ISSUE/DRAIN
//   dbg_state            current FSM state, for checkers
// ---------------------------------------------------------------------------
module uart_cmd_ctrl #(
    parameter int          TIMEOUT_CYC = 50000,
    parameter int          MAX_LEN     = 16,
    parameter logic [7:0]  SOF_BYTE    = 8'hAA
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_wr,
    output logic [23:0] cmd_addr,
    output logic [7:0]  cmd_len,
    output logic        wd_valid,
    input  logic        wd_ready,
    output logic [7:0]  wd_data,
    output logic        busy,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        ovr,
    output logic [3:0]  dbg_state
);

    localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TW        = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_TC = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_OP    = 4'd1,
        S_A2    = 4'd2,
        S_A1    = 4'd3,
        S_A0    = 4'd4,
        S_LEN   = 4'd5,
        S_PAY   = 4'd6,
        S_CHK   = 4'd7,
        S_ISSUE = 4'd8,
        S_DRAIN = 4'd9
    } state_t;

    state_t          state_q, state_d;
    logic            wr_q, wr_d;
    logic [23:0]     addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      chk_q, chk_d;
    logic            frame_err_q, frame_err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            ovr_q, ovr_d;
    logic            mem_we;
    logic            in_frame;
    logic            last_idx;
    logic [7:0]      pay_mem [MAX_LEN];

    // ---------------- state register ----------------
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            chk_q       <= '0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            chk_q       <= chk_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            ovr_q       <= ovr_d;
        end
    end

    // The payload buffer needs no reset. DRAIN only reads entries that were
    // written earlier in the same frame.
    always_ff @(posedge sclk) begin
        if (mem_we) begin
            pay_mem[idx_q] <= rx_data;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        len_d       = len_q;
        idx_d       = idx_q;
        tmo_d       = '0;
        chk_d       = chk_q;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        ovr_d       = 1'b0;
        mem_we      = 1'b0;

        in_frame = (state_q inside {S_OP, S_A2, S_A1, S_A0, S_LEN, S_PAY, S_CHK});
        last_idx = (8'(idx_q) == (len_q - 8'd1));

        // Inter-byte timeout. A byte arriving at the terminal count wins,
        // because the count is only examined in cycles without rx_vld.
        if (in_frame && !rx_vld) begin
            if (tmo_q == TMO_TC) begin
                state_d     = S_IDLE;
                frame_err_d = 1'b1;
                err_code_d  = 2'd3;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_vld && (rx_data == SOF_BYTE)) begin
                    state_d = S_OP;
                    chk_d   = 8'h00;
                    idx_d   = '0;
                end
            end
            S_OP: begin
                if (rx_vld) begin
                    chk_d = chk_q ^ rx_data;
                    if (rx_data == 8'h01) begin
                        wr_d    = 1'b1;
                        state_d = S_A2;
                    end else if (rx_data == 8'h02) begin
                        wr_d    = 1'b0;
                        state_d = S_A2;
                    end else begin
                        state_d     = S_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd0;
                    end
                end
            end
            S_A2: begin
                if (rx_vld) begin
                    chk_d          = chk_q ^ rx_data;
                    addr_d[23:16]  = rx_data;
                    state_d        = S_A1;
                end
            end
            S_A1: begin
                if (rx_vld) begin
                    chk_d         = chk_q ^ rx_data;
                    addr_d[15:8]  = rx_data;
                    state_d       = S_A0;
                end
            end
            S_A0: begin
                if (rx_vld) begin
                    chk_d        = chk_q ^ rx_data;
                    addr_d[7:0]  = rx_data;
                    state_d      = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_vld) begin
                    chk_d = chk_q ^ rx_data;
                    len_d = rx_data;
                    idx_d = '0;
                    if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
                        state_d     = S_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                    end else begin
                        state_d = wr_q ? S_PAY : S_CHK;
                    end
                end
            end
            S_PAY: begin
                if (rx_vld) begin
                    chk_d  = chk_q ^ rx_data;
                    mem_we = 1'b1;
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = S_CHK;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            S_CHK: begin
                if (rx_vld) begin
                    if (rx_data == chk_q) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d     = S_IDLE;
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                    end
                end
            end
            S_ISSUE: begin
                ovr_d = rx_vld;
                if (cmd_ready) begin
                    idx_d   = '0;
                    state_d = wr_q ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                ovr_d = rx_vld;
                if (wd_ready) begin
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        cmd_valid = (state_q == S_ISSUE);
        wd_valid  = (state_q == S_DRAIN);
        busy      = (state_q != S_IDLE);
        // wd_data is gated so that it reads zero outside DRAIN, including
        // after reset while the buffer is still unwritten.
        wd_data   = (state_q == S_DRAIN) ? pay_mem[idx_q] : 8'h00;
        cmd_wr    = wr_q;
        cmd_addr  = addr_q;
        cmd_len   = len_q;
        frame_err = frame_err_q;
        err_code  = err_code_q;
        ovr       = ovr_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

  localparam int TIMEOUT_CYC = 50000;

  logic        sclk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wd_valid;
  logic        wd_ready;
  logic [7:0]  wd_data;
  logic        busy;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        ovr;
  logic [3:0]  dbg_state;

  uart_cmd_ctrl #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_LEN     (16),
    .SOF_BYTE    (8'hAA)
  ) dut (
    .sclk      (sclk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_vld    (rx_vld),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .busy      (busy),
    .frame_err (frame_err),
    .err_code  (err_code),
    .ovr       (ovr),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial sclk = 1'b0;
  always #10 sclk = ~sclk;

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // fb holds the frame bytes with the first byte sent at index n-1.
  typedef struct packed {
    logic [23:0][7:0] fb;
    logic [4:0]       n;
    logic             is_err;
    logic [1:0]       code;
    logic             wr;
    logic [23:0]      addr;
    logic [7:0]       len;
    logic [4:0]       pay_off;
  } vec_t;

  vec_t vecs [10];

  task automatic mk(input int i, input logic [191:0] fb, input int n, input logic is_err,
                    input logic [1:0] code, input logic wr, input logic [23:0] addr,
                    input logic [7:0] len, input int pay_off);
    vecs[i].fb      = fb;
    vecs[i].n       = 5'(n);
    vecs[i].is_err  = is_err;
    vecs[i].code    = code;
    vecs[i].wr      = wr;
    vecs[i].addr    = addr;
    vecs[i].len     = len;
    vecs[i].pay_off = 5'(pay_off);
  endtask

  // ---------------- driver tasks ----------------
  // Each task starts and ends 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_vld  = 1'b1;
    @(posedge sclk);
    #1;
    rx_vld  = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    for (int i = 0; i < int'(v.n); i++) begin
      send_byte(v.fb[int'(v.n) - 1 - i]);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0] exp_q [$];
    exp_q.delete();
    if (!v.is_err && v.wr) begin
      for (int j = 0; j < int'(v.len); j++) begin
        exp_q.push_back(v.fb[int'(v.n) - 1 - (int'(v.pay_off) + j)]);
      end
    end
    send_frame(v);
    if (v.is_err) begin
      check($sformatf("v%0d frame_err", id), frame_err, 1'b1);
      check($sformatf("v%0d err_code", id), err_code, v.code);
      check($sformatf("v%0d no cmd_valid", id), cmd_valid, 1'b0);
      check($sformatf("v%0d idle", id), busy, 1'b0);
      @(posedge sclk);
      #1;
      check($sformatf("v%0d frame_err pulse", id), frame_err, 1'b0);
      check($sformatf("v%0d err_code held", id), err_code, v.code);
    end else begin
      check($sformatf("v%0d cmd_valid", id), cmd_valid, 1'b1);
      check($sformatf("v%0d cmd_wr", id), cmd_wr, v.wr);
      check($sformatf("v%0d cmd_addr", id), cmd_addr, v.addr);
      check($sformatf("v%0d cmd_len", id), cmd_len, v.len);
      check($sformatf("v%0d no frame_err", id), frame_err, 1'b0);
      @(posedge sclk);
      #1;
      check($sformatf("v%0d cmd_valid drop", id), cmd_valid, 1'b0);
      while (exp_q.size() > 0) begin
        check($sformatf("v%0d wd_valid", id), wd_valid, 1'b1);
        check($sformatf("v%0d wd_data", id), wd_data, exp_q.pop_front());
        @(posedge sclk);
        #1;
      end
      check($sformatf("v%0d wd_valid low", id), wd_valid, 1'b0);
      check($sformatf("v%0d busy low", id), busy, 1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " cmd_valid"}, cmd_valid, 1'b0);
    check({tag, " cmd_wr"}, cmd_wr, 1'b0);
    check({tag, " cmd_addr"}, cmd_addr, 24'h0);
    check({tag, " cmd_len"}, cmd_len, 8'h0);
    check({tag, " wd_valid"}, wd_valid, 1'b0);
    check({tag, " wd_data"}, wd_data, 8'h0);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " frame_err"}, frame_err, 1'b0);
    check({tag, " err_code"}, err_code, 2'd0);
    check({tag, " ovr"}, ovr, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int j;
    logic [7:0] exp_pay [3];
    exp_pay[0] = 8'h11;
    exp_pay[1] = 8'h22;
    exp_pay[2] = 8'h33;

    mk(0, 192'({8'hAA,8'h01,8'h00,8'h12,8'h34,8'h03,8'h11,8'h22,8'h33,8'h24}), 10, 1'b0, 2'd0, 1'b1, 24'h001234, 8'd3, 6);
    mk(1, 192'({8'hAA,8'h02,8'h00,8'h00,8'h10,8'h08,8'h1A}), 7, 1'b0, 2'd0, 1'b0, 24'h000010, 8'd8, 0);
    mk(2, 192'({8'hAA,8'h01,8'h00,8'h12,8'h34,8'h03,8'h11,8'h22,8'h33,8'h25}), 10, 1'b1, 2'd2, 1'b0, 24'h0, 8'd0, 0);
    mk(3, 192'({8'hAA,8'h01,8'h00,8'h12,8'h34,8'h03,8'h11,8'h22,8'h33,8'h24}), 10, 1'b0, 2'd0, 1'b1, 24'h001234, 8'd3, 6);
    mk(4, 192'({8'hAA,8'h05}), 2, 1'b1, 2'd0, 1'b0, 24'h0, 8'd0, 0);
    mk(5, 192'({8'hAA,8'h01,8'h00,8'h12,8'h34,8'h00}), 6, 1'b1, 2'd1, 1'b0, 24'h0, 8'd0, 0);
    mk(6, 192'({8'hAA,8'h01,8'h00,8'h12,8'h34,8'h11}), 6, 1'b1, 2'd1, 1'b0, 24'h0, 8'd0, 0);
    // A leading non-SOF byte is ignored in IDLE.
    mk(7, 192'({8'h55,8'hAA,8'h01,8'hAB,8'hCD,8'hEF,8'h01,8'h5A,8'hD3}), 9, 1'b0, 2'd0, 1'b1, 24'hABCDEF, 8'd1, 7);
    mk(8, 192'({8'hAA,8'h02,8'hFF,8'hFF,8'hFF,8'h10,8'hED}), 7, 1'b0, 2'd0, 1'b0, 24'hFFFFFF, 8'd16, 0);
    mk(9, 192'({8'hAA,8'h01,8'h00,8'h00,8'h00,8'h10,
                8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,
                8'h08,8'h09,8'h0A,8'h0B,8'h0C,8'h0D,8'h0E,8'h0F,8'h11}), 23, 1'b0, 2'd0, 1'b1, 24'h000000, 8'd16, 6);

    // ---- clock/reset ----
    reset     = 1'b0;
    rx_data   = 8'h00;
    rx_vld    = 1'b0;
    cmd_ready = 1'b1;
    wd_ready  = 1'b1;
    repeat (3) @(posedge sclk);
    #5;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge sclk);
    #1;
    check_all_zero("post-reset");

    // ---- table-driven frames ----
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // ---- backpressure and overrun ----
    cmd_ready = 1'b0;
    send_frame(vecs[0]);
    for (int c = 0; c < 100; c++) begin
      check("stall cmd_valid", cmd_valid, 1'b1);
      check("stall cmd_wr", cmd_wr, 1'b1);
      check("stall cmd_addr", cmd_addr, 24'h001234);
      check("stall cmd_len", cmd_len, 8'd3);
      rx_data = 8'h55;
      rx_vld  = (c == 50);
      @(posedge sclk);
      #1;
      rx_vld = 1'b0;
      if (c == 50) check("ovr in ISSUE", ovr, 1'b1);
      if (c == 51) check("ovr pulse in ISSUE", ovr, 1'b0);
    end
    cmd_ready = 1'b1;
    @(posedge sclk);
    #1;
    cmd_ready = 1'b0;
    check("stall cmd_valid drop", cmd_valid, 1'b0);
    j = 0;
    for (int k = 0; k < 20 && j < 3; k++) begin
      wd_ready = (k % 2 == 0);
      rx_data  = 8'hAA;
      rx_vld   = (k == 1);
      check("drain wd_valid", wd_valid, 1'b1);
      check("drain wd_data", wd_data, exp_pay[j]);
      @(posedge sclk);
      #1;
      rx_vld = 1'b0;
      if (k == 1) begin
        check("ovr in DRAIN", ovr, 1'b1);
        check("ovr keeps busy", busy, 1'b1);
      end
      if (wd_ready) j++;
    end
    check("drain count", j, 3);
    check("drain wd_valid low", wd_valid, 1'b0);
    check("drain busy low", busy, 1'b0);
    check("drain ovr clear", ovr, 1'b0);
    cmd_ready = 1'b1;
    wd_ready  = 1'b1;

    // ---- timeout ----
    send_byte(8'hAA);
    send_byte(8'h01);
    n = 0;
    while (!frame_err && n < TIMEOUT_CYC + 100) begin
      @(posedge sclk);
      #1;
      n++;
    end
    check("timeout seen", frame_err, 1'b1);
    n_cmp++;
    if (n < TIMEOUT_CYC - 1 || n > TIMEOUT_CYC) begin
      n_bad++;
      $display("FAIL timeout cycles: got %0d expected %0d", n, TIMEOUT_CYC);
    end
    check("timeout err_code", err_code, 2'd3);
    check("timeout busy", busy, 1'b0);
    send_byte(8'h55);
    check("stray byte busy", busy, 1'b0);
    check("stray byte frame_err", frame_err, 1'b0);
    check("stray byte err_code", err_code, 2'd3);

    // ---- reset during PAY ----
    for (int i = 0; i < 7; i++) begin
      send_byte(vecs[0].fb[9 - i]);
    end
    check("pay busy", busy, 1'b1);
    #4;
    reset = 1'b0;
    #1;
    check_all_zero("async reset");
    @(posedge sclk);
    #5;
    reset = 1'b1;
    @(posedge sclk);
    #1;
    check("after reset idle", busy, 1'b0);
    run_vec(vecs[0], 100);

    // ---- final report ----
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
